// File: rtl/ram_port_ctrl_if.sv
// -----------------------------------------------------------------------------
// ram_port_ctrl_if
// Upstream request/response bundle for ram_port_ctrl.
//
//   req_valid   request present                  (master -> slave)
//   req_ready   controller can accept a request  (slave  -> master)
//   req_we      1 = store, 0 = load
//   req_size    0 = byte, 1 = half, 2/3 = word
//   req_signed  sign-extend loads when 1
//   req_addr    byte address
//   req_wdata   store data, little-endian (low byte first)
//   rsp_valid   one-cycle completion pulse       (slave  -> master)
//   rsp_rdata   load result, 0 for stores
//   rsp_err     misalignment error, qualified by rsp_valid
//
// The controller uses the slave modport; the requester uses master.
// -----------------------------------------------------------------------------
interface ram_port_ctrl_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [1:0]            req_size;
   logic                  req_signed;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/ram_port_ctrl.sv
// -----------------------------------------------------------------------------
// ram_port_ctrl
// Initiator-side controller for port b of the byte-addressed dual-port RAM.
// Stores are split into 1, 2 or 4 single-byte writes; loads use the RAM's
// one-cycle registered-address latency and are then zero/sign-extended.
//
// Ports:
//   clk, rst   clock; asynchronous active-high reset
//   bus        request/response bundle (ram_port_ctrl_if.slave)
//   ram_we     RAM we_b, high only while storing
//   ram_addr   RAM addr_b
//   ram_din    RAM din_b, byte in [7:0], upper bits 0
//   ram_dout   RAM dout_b, word at the registered address
//
// Optional feature: define RAM_PORT_CTRL_ALIGN_CHECK_EN to reject misaligned
// half/word accesses through an ERR state with rsp_err = 1 and no RAM access.
// Without it rsp_err is tied to 0 and misaligned accesses proceed.
// -----------------------------------------------------------------------------
module ram_port_ctrl #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   ram_port_ctrl_if.slave        bus,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout
);

   typedef enum logic [2:0] {
      IDLE,
      STORE,
      LOAD_ADDR,
      LOAD_DATA
`ifdef RAM_PORT_CTRL_ALIGN_CHECK_EN
      , ERR
`endif
   } state_t;

   state_t                state, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [1:0]            size_q;
   logic                  signed_q;
   logic [1:0]            cnt_q, cnt_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [DATA_WIDTH-1:0] load_ext;
   logic                  last_byte;
   logic                  accept;
`ifdef RAM_PORT_CTRL_ALIGN_CHECK_EN
   logic                  rsp_err_q, rsp_err_d;
   logic                  misaligned;
`endif

   // Index of the final byte of the access: N-1 for N = 1, 2, 4.
   function automatic logic [1:0] last_idx(input logic [1:0] size);
      case (size)
         2'd0:    return 2'd0;
         2'd1:    return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

   assign accept    = (state == IDLE) && bus.req_valid;
   assign last_byte = (cnt_q == last_idx(size_q));

`ifdef RAM_PORT_CTRL_ALIGN_CHECK_EN
   // Judged on the live request fields, since they are captured on this edge.
   always_comb begin
      case (bus.req_size)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = bus.req_addr[0];
         default: misaligned = (bus.req_addr[1:0] != 2'b00);
      endcase
   end
`endif

   // Mask the RAM word down to the access size, then extend.
   always_comb begin
      load_ext = ram_dout;
      case (size_q)
         2'd0:    load_ext = {{(DATA_WIDTH-8){signed_q & ram_dout[7]}}, ram_dout[7:0]};
         2'd1:    load_ext = {{(DATA_WIDTH-16){signed_q & ram_dout[15]}}, ram_dout[15:0]};
         default: load_ext = ram_dout;
      endcase
   end

   // Next-state and response logic.
   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d     = state;
      cnt_d       = cnt_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
`ifdef RAM_PORT_CTRL_ALIGN_CHECK_EN
      rsp_err_d   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               cnt_d = 2'd0;
`ifdef RAM_PORT_CTRL_ALIGN_CHECK_EN
               if (misaligned) begin
                  // Error response is presented during the ERR cycle itself.
                  state_d     = ERR;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
               end else
`endif
               if (bus.req_we) state_d = STORE;
               else            state_d = LOAD_ADDR;
            end
         end
         STORE: begin
            if (last_byte) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = '0;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         // RAM registers ram_addr on the edge leaving this state.
         LOAD_ADDR: state_d = LOAD_DATA;
         LOAD_DATA: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = load_ext;
         end
`ifdef RAM_PORT_CTRL_ALIGN_CHECK_EN
         ERR:       state_d = IDLE;
`endif
         default:   state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt_q       <= 2'd0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
`ifdef RAM_PORT_CTRL_ALIGN_CHECK_EN
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         state       <= state_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
`ifdef RAM_PORT_CTRL_ALIGN_CHECK_EN
         rsp_err_q   <= rsp_err_d;
`endif
      end
   end

   // Request capture; upstream is free to change its fields after acceptance.
   // NOTE: these are reset along with the FSM so simulation never starts with
   // X on the request copy, even though the outputs are also gated by state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         size_q   <= 2'd0;
         signed_q <= 1'b0;
      end else if (accept) begin
         addr_q   <= bus.req_addr;
         wdata_q  <= bus.req_wdata;
         size_q   <= bus.req_size;
         signed_q <= bus.req_signed;
      end
   end

   // RAM port drive: address wraps naturally at 2^ADDR_WIDTH.
   always_comb begin
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_din  = '0;
      case (state)
         STORE: begin
            ram_we   = 1'b1;
            ram_addr = addr_q + ADDR_WIDTH'(cnt_q);
            ram_din  = {{(DATA_WIDTH-8){1'b0}}, wdata_q[{cnt_q, 3'b000} +: 8]};
         end
         LOAD_ADDR: ram_addr = addr_q;
         default: ;
      endcase
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
`ifdef RAM_PORT_CTRL_ALIGN_CHECK_EN
   assign bus.rsp_err   = rsp_err_q;
`else
   assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ram_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ram_port_ctrl
// Bench for ram_port_ctrl with a behavioural byte RAM on port b (registered
// read address, one byte written per edge). Stimulus pushes the expected
// response (data, error flag, arrival cycle) into a scoreboard queue; a
// monitor pops and compares on every rsp_valid pulse. Store byte traffic is
// logged and compared against the request, and RAM contents are inspected
// after a reset that interrupts a store.
// Expectations follow RAM_PORT_CTRL_ALIGN_CHECK_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_ram_port_ctrl;

   localparam int AW = 16;
   localparam int DW = 32;

   logic          clk;
   logic          rst;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;

   ram_port_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   ram_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_dout (ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural RAM, port b.
   logic [7:0]    mem [0:65535];
   logic [AW-1:0] rd_addr;
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din[7:0];
      rd_addr <= ram_addr;
   end
   assign ram_dout = {mem[AW'(rd_addr + 16'd3)], mem[AW'(rd_addr + 16'd2)],
                      mem[AW'(rd_addr + 16'd1)], mem[rd_addr]};

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] size);
      case (size)
         2'd0:    return 1;
         2'd1:    return 2;
         default: return 4;
      endcase
   endfunction

   function automatic bit align_err(input logic [1:0] size, input logic [15:0] addr);
`ifdef RAM_PORT_CTRL_ALIGN_CHECK_EN
      case (size)
         2'd0:    return 1'b0;
         2'd1:    return addr[0];
         default: return addr[1:0] != 2'b00;
      endcase
`else
      return 1'b0;
`endif
   endfunction

   // Scoreboard.
   typedef struct {
      string       name;
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   always @(negedge clk) begin
      if (!rst && bus.rsp_valid) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp: got rsp_valid at cycle %0d expected none", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_rdata"}, bus.rsp_rdata, e.rdata);
            check({e.name, "_err"}, 32'(bus.rsp_err), 32'(e.err));
            check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
         end
      end
   end

   // Store byte log: {addr, byte}.
   logic [23:0] wlog[$];
   always @(negedge clk) begin
      if (!rst && ram_we) begin
         wlog.push_back({ram_addr, ram_din[7:0]});
         check("ram_din_upper", ram_din[31:8], 32'h0);
      end
   end

   // Drive one request starting at the next negedge and return just after the
   // edge that accepts it. acc = that edge's number; waited = ready-low cycles.
   task automatic issue(input string name, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [15:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input bit track,
                        output int acc, output int waited);
      exp_t e;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      waited = 0;
      while (!bus.req_ready && waited < 100) begin
         waited++;
         @(negedge clk);
      end
      acc = cyc + 1;
      if (!bus.req_ready) begin
         checks++;
         failures++;
         $display("FAIL %s_accept: got no req_ready within 100 cycles expected acceptance", name);
         return;
      end
      if (track) begin
         e.name = name;
         if (align_err(size, addr)) begin
            e.rdata = 32'h0; e.err = 1'b1; e.cyc = acc;
         end else if (we) begin
            e.rdata = 32'h0; e.err = 1'b0; e.cyc = acc + nbytes(size);
         end else begin
            e.rdata = exp_rdata; e.err = 1'b0; e.cyc = acc + 2;
         end
         sb.push_back(e);
      end
      @(posedge clk);
   endtask

   task automatic wait_idle(input string name);
      @(negedge clk);
      bus.req_valid = 1'b0;
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL %s_drain: got %0d pending responses expected 0", name, sb.size());
      end
      @(negedge clk);
   endtask

   // Compare logged RAM writes with what the store should have produced.
   task automatic check_writes(input string name, input logic [1:0] size,
                               input logic [15:0] addr, input logic [31:0] wdata);
      int n;
      n = align_err(size, addr) ? 0 : nbytes(size);
      check({name, "_wcount"}, 32'(wlog.size()), 32'(n));
      for (int k = 0; k < n && k < wlog.size(); k++)
         check($sformatf("%s_w%0d", name, k), 32'(wlog[k]),
               {8'h0, 16'(addr + 16'(k)), wdata[8*k +: 8]});
      wlog.delete();
   endtask

   int acc1, acc2, acc3, w1, w2, w3;

   initial begin
      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_size   = 2'd0;
      bus.req_signed = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;

      // Reset values.
      repeat (2) @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      check("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
      check("rst_ram_we",    32'(ram_we), 32'd0);
      check("rst_ram_addr",  32'(ram_addr), 32'h0);
      check("rst_ram_din",   ram_din, 32'h0);
      rst = 1'b0;
      wlog.delete();

      // Word store and readback.
      issue("st_w10", 1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b1, acc1, w1);
      wait_idle("st_w10");
      check_writes("st_w10", 2'd2, 16'h0010, 32'hDEADBEEF);
      issue("ld_w10", 1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b1, acc1, w1);
      wait_idle("ld_w10");
      repeat (3) @(negedge clk);
      check("rdata_hold", bus.rsp_rdata, 32'hDEADBEEF);

      // 0x80 at 0x20, 0x7F at 0x21, then extension cases.
      issue("st_h20", 1'b1, 2'd1, 1'b0, 16'h0020, 32'h00007F80, 32'h0, 1'b1, acc1, w1);
      wait_idle("st_h20");
      check_writes("st_h20", 2'd1, 16'h0020, 32'h00007F80);
      issue("ld_bs20", 1'b0, 2'd0, 1'b1, 16'h0020, 32'h0, 32'hFFFFFF80, 1'b1, acc1, w1);
      issue("ld_bu20", 1'b0, 2'd0, 1'b0, 16'h0020, 32'h0, 32'h00000080, 1'b1, acc1, w1);
      issue("ld_hs20", 1'b0, 2'd1, 1'b1, 16'h0020, 32'h0, 32'h00007F80, 1'b1, acc1, w1);
      issue("ld_bs21", 1'b0, 2'd0, 1'b1, 16'h0021, 32'h0, 32'h0000007F, 1'b1, acc1, w1);
      wait_idle("ext20");

      // Half with bit 15 set.
      issue("st_h30", 1'b1, 2'd1, 1'b0, 16'h0030, 32'h12348001, 32'h0, 1'b1, acc1, w1);
      wait_idle("st_h30");
      check_writes("st_h30", 2'd1, 16'h0030, 32'h12348001);
      issue("ld_hs30", 1'b0, 2'd1, 1'b1, 16'h0030, 32'h0, 32'hFFFF8001, 1'b1, acc1, w1);
      issue("ld_hu30", 1'b0, 2'd1, 1'b0, 16'h0030, 32'h0, 32'h00008001, 1'b1, acc1, w1);
      wait_idle("ext30");

      // Byte store writes exactly one byte.
      issue("st_b50", 1'b1, 2'd0, 1'b0, 16'h0050, 32'h123456A5, 32'h0, 1'b1, acc1, w1);
      wait_idle("st_b50");
      check_writes("st_b50", 2'd0, 16'h0050, 32'h123456A5);

      // Address wrap-around; size 3 behaves as word.
      issue("st_wffff", 1'b1, 2'd2, 1'b0, 16'hFFFF, 32'h11223344, 32'h0, 1'b1, acc1, w1);
      wait_idle("st_wffff");
      check_writes("st_wffff", 2'd2, 16'hFFFF, 32'h11223344);
      issue("st_s3_70", 1'b1, 2'd3, 1'b0, 16'h0070, 32'h55667788, 32'h0, 1'b1, acc1, w1);
      wait_idle("st_s3_70");
      check_writes("st_s3_70", 2'd3, 16'h0070, 32'h55667788);
      issue("ld_s3_70", 1'b0, 2'd3, 1'b1, 16'h0070, 32'h0, 32'h55667788, 1'b1, acc1, w1);
      wait_idle("ld_s3_70");

      // Misaligned half store at 0x0003.
      issue("st_h03", 1'b1, 2'd1, 1'b0, 16'h0003, 32'h0000BEEF, 32'h0, 1'b1, acc1, w1);
      wait_idle("st_h03");
      check_writes("st_h03", 2'd1, 16'h0003, 32'h0000BEEF);
      issue("ld_hu03", 1'b0, 2'd1, 1'b0, 16'h0003, 32'h0, 32'h0000BEEF, 1'b1, acc1, w1);
      wait_idle("ld_hu03");

      // Back-to-back with req_valid held high: store, load, byte store.
      issue("b2b_st", 1'b1, 2'd2, 1'b0, 16'h0060, 32'hCAFEF00D, 32'h0, 1'b1, acc1, w1);
      issue("b2b_ld", 1'b0, 2'd2, 1'b0, 16'h0060, 32'h0, 32'hCAFEF00D, 1'b1, acc2, w2);
      issue("b2b_sb", 1'b1, 2'd0, 1'b0, 16'h0064, 32'h000000E7, 32'h0, 1'b1, acc3, w3);
      check("b2b_ld_wait", 32'(w2), 32'd4);
      check("b2b_ld_accept", 32'(acc2 - acc1), 32'd5);
      check("b2b_sb_wait", 32'(w3), 32'd2);
      check("b2b_sb_accept", 32'(acc3 - acc2), 32'd3);
      wait_idle("b2b");
      wlog.delete();

      // Reset during STORE cycle 1.
      issue("pre_w40", 1'b1, 2'd2, 1'b0, 16'h0040, 32'h44332211, 32'h0, 1'b1, acc1, w1);
      wait_idle("pre_w40");
      issue("rst_w40", 1'b1, 2'd2, 1'b0, 16'h0040, 32'hAABBCCDD, 32'h0, 1'b0, acc1, w1);
      @(negedge clk);
      @(negedge clk);
      check("mid_ram_we", 32'(ram_we), 32'd1);
      check("mid_ram_addr", 32'(ram_addr), 32'h0041);
      #1 rst = 1'b1;
      #1;
      check("abort_ram_we", 32'(ram_we), 32'd0);
      check("abort_ram_addr", 32'(ram_addr), 32'h0);
      check("abort_req_ready", 32'(bus.req_ready), 32'd1);
      check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      check("abort_mem40", 32'(mem[16'h0040]), 32'h000000DD);
      check("abort_mem41", 32'(mem[16'h0041]), 32'h00000022);
      check("abort_mem42", 32'(mem[16'h0042]), 32'h00000033);
      check("abort_mem43", 32'(mem[16'h0043]), 32'h00000044);
      issue("ld_w40", 1'b0, 2'd2, 1'b0, 16'h0040, 32'h0, 32'h443322DD, 1'b1, acc1, w1);
      wait_idle("ld_w40");

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
